// File: rtl/master_start_pkg.sv
// rtl/master_start_pkg.sv - shared constants, state encoding and field layout for the MASTER_START loader
package master_start_pkg;

    // Frame framing
    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         PAYLOAD_LEN     = 40;
    localparam int         SHADOW_W        = PAYLOAD_LEN * 8;
    localparam int         TIMEOUT_CYC_DEF = 12500;

    // Field widths in bits
    localparam int W_DDS_FREQ   = 48;
    localparam int W_DDS_DFREQ  = 48;
    localparam int W_DDS_RATE   = 32;
    localparam int W_TIME_START = 48;
    localparam int W_N_IMPULS   = 16;
    localparam int W_TI         = 32;
    localparam int W_TP         = 32;
    localparam int W_TBLANK1    = 32;
    localparam int W_TBLANK2    = 32;

    // Field byte offsets inside the payload (first payload byte = offset 0)
    localparam int OFS_DDS_FREQ   = 0;
    localparam int OFS_DDS_DFREQ  = 6;
    localparam int OFS_DDS_RATE   = 12;
    localparam int OFS_TIME_START = 16;
    localparam int OFS_N_IMPULS   = 22;
    localparam int OFS_TI         = 24;
    localparam int OFS_TP         = 28;
    localparam int OFS_TBLANK1    = 32;
    localparam int OFS_TBLANK2    = 36;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        COMMIT  = 2'd3
    } ld_state_t;

    typedef struct packed {
        logic [W_DDS_FREQ-1:0]   dds_freq;
        logic [W_DDS_DFREQ-1:0]  dds_delta_freq;
        logic [W_DDS_RATE-1:0]   dds_delta_rate;
        logic [W_TIME_START-1:0] time_start;
        logic [W_N_IMPULS-1:0]   n_impuls;
        logic [W_TI-1:0]         interval_ti;
        logic [W_TP-1:0]         interval_tp;
        logic [W_TBLANK1-1:0]    tblank1;
        logic [W_TBLANK2-1:0]    tblank2;
    } ms_params_t;

    // MSB index in the shadow register of the field starting at byte offset ofs.
    // The first received byte ends up in the top byte after the full payload is shifted in.
    function automatic int shadow_msb(input int ofs);
        return SHADOW_W - 1 - 8 * ofs;
    endfunction

endpackage

// File: rtl/ms_byte_timer.sv
// rtl/ms_byte_timer.sv - clearable inter-byte down-counter with expiry pulse
//
// Ports:
//   clk_i      in  clock
//   resetn_i   in  synchronous active-low reset
//   run_i      in  timing is active (frame in progress); counter reloads while low
//   clear_i    in  a byte was accepted this cycle; counter reloads
//   expired_o  out combinational: no byte for TIMEOUT_CYC clocks, asserted in the
//                  cycle whose edge should abort the frame
module ms_byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 12500
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    // Counts remaining idle clocks; reaching zero is equivalent to an idle
    // up-counter having reached TIMEOUT_CYC-1.
    always_ff @(posedge clk_i) begin
        if (!resetn_i || clear_i || !run_i) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = run_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/master_start_loader.sv
// rtl/master_start_loader.sv - byte-serial frame receiver that loads and strobes the MASTER_START parameters
//
// Ports:
//   CLK, RESET_N            clock, synchronous active-low reset
//   DIN[7:0], DIN_VALID     incoming byte stream
//   DIN_READY               byte taken when DIN_VALID && DIN_READY (low only in COMMIT)
//   WR_DATA                 1-clk strobe: MEM_* hold a freshly validated frame
//   MEM_*                   committed parameter fields, stable between strobes
//   BUSY                    frame in progress
//   ERR_CRC, ERR_TIMEOUT    1-clk pulses: frame dropped on bad checksum / inter-byte timeout
//   FRAME_CNT[15:0]         committed frame count, wraps
module master_start_loader
    import master_start_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  DIN,
    input  logic        DIN_VALID,
    output logic        DIN_READY,
    output logic        WR_DATA,
    output logic [47:0] MEM_DDS_freq,
    output logic [47:0] MEM_DDS_delta_freq,
    output logic [31:0] MEM_DDS_delta_rate,
    output logic [47:0] MEM_TIME_START,
    output logic [15:0] MEM_N_impuls,
    output logic [31:0] MEM_Interval_Ti,
    output logic [31:0] MEM_Interval_Tp,
    output logic [31:0] MEM_Tblank1,
    output logic [31:0] MEM_Tblank2,
    output logic        BUSY,
    output logic        ERR_CRC,
    output logic        ERR_TIMEOUT,
    output logic [15:0] FRAME_CNT
);

    localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_LEN - 1);

    ld_state_t           state_q;
    logic [5:0]          idx_q;
    logic [7:0]          sum_q;
    logic [SHADOW_W-1:0] shadow_q;
    ms_params_t          mem_q;
    ms_params_t          shadow_fields;
    logic                wr_q;
    logic                err_crc_q;
    logic                err_to_q;
    logic [15:0]         frame_cnt_q;
    logic                accept;
    logic                timer_run;
    logic                timer_expired;

    assign DIN_READY = (state_q != COMMIT);
    assign accept    = DIN_VALID && DIN_READY;
    assign timer_run = (state_q == PAYLOAD) || (state_q == CHECK);

    ms_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_i     (CLK),
        .resetn_i  (RESET_N),
        .run_i     (timer_run),
        .clear_i   (accept),
        .expired_o (timer_expired)
    );

    // Unpack the fully shifted shadow into named fields by byte offset.
    always_comb begin
        shadow_fields                = '0;
        shadow_fields.dds_freq       = shadow_q[shadow_msb(OFS_DDS_FREQ)   -: W_DDS_FREQ];
        shadow_fields.dds_delta_freq = shadow_q[shadow_msb(OFS_DDS_DFREQ)  -: W_DDS_DFREQ];
        shadow_fields.dds_delta_rate = shadow_q[shadow_msb(OFS_DDS_RATE)   -: W_DDS_RATE];
        shadow_fields.time_start     = shadow_q[shadow_msb(OFS_TIME_START) -: W_TIME_START];
        shadow_fields.n_impuls       = shadow_q[shadow_msb(OFS_N_IMPULS)   -: W_N_IMPULS];
        shadow_fields.interval_ti    = shadow_q[shadow_msb(OFS_TI)         -: W_TI];
        shadow_fields.interval_tp    = shadow_q[shadow_msb(OFS_TP)         -: W_TP];
        shadow_fields.tblank1        = shadow_q[shadow_msb(OFS_TBLANK1)    -: W_TBLANK1];
        shadow_fields.tblank2        = shadow_q[shadow_msb(OFS_TBLANK2)    -: W_TBLANK2];
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            shadow_q    <= '0;
            mem_q       <= '0;
            wr_q        <= 1'b0;
            err_crc_q   <= 1'b0;
            err_to_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            wr_q      <= 1'b0;
            err_crc_q <= 1'b0;
            err_to_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && (DIN == SYNC_BYTE)) begin
                        state_q <= PAYLOAD;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        shadow_q <= {shadow_q[SHADOW_W-9:0], DIN};
                        sum_q    <= sum_q + DIN;
                        idx_q    <= idx_q + 6'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= CHECK;
                        end
                    end else if (timer_expired) begin
                        err_to_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (DIN == sum_q) begin
                            mem_q       <= shadow_fields;
                            wr_q        <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state_q     <= COMMIT;
                        end else begin
                            err_crc_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else if (timer_expired) begin
                        err_to_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WR_DATA            = wr_q;
    assign ERR_CRC            = err_crc_q;
    assign ERR_TIMEOUT        = err_to_q;
    assign BUSY               = (state_q != IDLE);
    assign FRAME_CNT          = frame_cnt_q;
    assign MEM_DDS_freq       = mem_q.dds_freq;
    assign MEM_DDS_delta_freq = mem_q.dds_delta_freq;
    assign MEM_DDS_delta_rate = mem_q.dds_delta_rate;
    assign MEM_TIME_START     = mem_q.time_start;
    assign MEM_N_impuls       = mem_q.n_impuls;
    assign MEM_Interval_Ti    = mem_q.interval_ti;
    assign MEM_Interval_Tp    = mem_q.interval_tp;
    assign MEM_Tblank1        = mem_q.tblank1;
    assign MEM_Tblank2        = mem_q.tblank2;

endmodule

// File: tb/tb_master_start_loader.sv
// tb/tb_master_start_loader.sv - directed self-checking bench for master_start_loader
module tb_master_start_loader;

    localparam int TO = 12500;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] rate;
        logic [47:0] tstart;
        logic [15:0] n;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } tb_frame_t;

    typedef struct packed {
        tb_frame_t   f;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  DIN;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic        WR_DATA;
    logic [47:0] MEM_DDS_freq;
    logic [47:0] MEM_DDS_delta_freq;
    logic [31:0] MEM_DDS_delta_rate;
    logic [47:0] MEM_TIME_START;
    logic [15:0] MEM_N_impuls;
    logic [31:0] MEM_Interval_Ti;
    logic [31:0] MEM_Interval_Tp;
    logic [31:0] MEM_Tblank1;
    logic [31:0] MEM_Tblank2;
    logic        BUSY;
    logic        ERR_CRC;
    logic        ERR_TIMEOUT;
    logic [15:0] FRAME_CNT;

    master_start_loader dut (
        .CLK                (CLK),
        .RESET_N            (RESET_N),
        .DIN                (DIN),
        .DIN_VALID          (DIN_VALID),
        .DIN_READY          (DIN_READY),
        .WR_DATA            (WR_DATA),
        .MEM_DDS_freq       (MEM_DDS_freq),
        .MEM_DDS_delta_freq (MEM_DDS_delta_freq),
        .MEM_DDS_delta_rate (MEM_DDS_delta_rate),
        .MEM_TIME_START     (MEM_TIME_START),
        .MEM_N_impuls       (MEM_N_impuls),
        .MEM_Interval_Ti    (MEM_Interval_Ti),
        .MEM_Interval_Tp    (MEM_Interval_Tp),
        .MEM_Tblank1        (MEM_Tblank1),
        .MEM_Tblank2        (MEM_Tblank2),
        .BUSY               (BUSY),
        .ERR_CRC            (ERR_CRC),
        .ERR_TIMEOUT        (ERR_TIMEOUT),
        .FRAME_CNT          (FRAME_CNT)
    );

    always #4 CLK = ~CLK;

    int        vectors     = 0;
    int        miscompares = 0;
    int        wr_count    = 0;
    int        crc_count   = 0;
    int        to_count    = 0;
    int        cyc         = 0;
    int        last_acc    = 0;
    logic      mon_en      = 1'b0;
    logic      prev_wr     = 1'b0;
    exp_t      sb[$];
    exp_t      e;
    tb_frame_t f1, f2, f3, f4;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every WR_DATA pulse pops one expected frame.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (WR_DATA === 1'b1) begin
                wr_count++;
                check("wr_single_clk", prev_wr, 0);
                check("wr_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("mem_freq",   MEM_DDS_freq,       e.f.freq);
                    check("mem_dfreq",  MEM_DDS_delta_freq, e.f.dfreq);
                    check("mem_rate",   MEM_DDS_delta_rate, e.f.rate);
                    check("mem_tstart", MEM_TIME_START,     e.f.tstart);
                    check("mem_n",      MEM_N_impuls,       e.f.n);
                    check("mem_ti",     MEM_Interval_Ti,    e.f.ti);
                    check("mem_tp",     MEM_Interval_Tp,    e.f.tp);
                    check("mem_tb1",    MEM_Tblank1,        e.f.tb1);
                    check("mem_tb2",    MEM_Tblank2,        e.f.tb2);
                    check("frame_cnt",  FRAME_CNT,          e.cnt);
                end
            end
            if (ERR_CRC === 1'b1) crc_count++;
            if (ERR_TIMEOUT === 1'b1) to_count++;
            prev_wr = WR_DATA;
        end
    end

    // Byte k of the framed stream: 0 = sync, 1..40 payload, 41 = checksum (+adj).
    function automatic logic [7:0] frame_byte(input tb_frame_t f, input logic [7:0] adj, input int k);
        logic [319:0] v;
        logic [7:0]   s;
        v = f;
        if (k == 0) return 8'hA5;
        if (k <= 40) return v[8*(41-k)-1 -: 8];
        s = adj;
        for (int j = 1; j <= 40; j++) s = s + v[8*(41-j)-1 -: 8];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        DIN       = b;
        DIN_VALID = 1'b1;
        n = 0;
        while (DIN_READY !== 1'b1 && n < 8) begin
            @(posedge CLK); #1;
            n++;
        end
        check("din_ready", DIN_READY, 1);
        @(posedge CLK); #1;
        last_acc = cyc;
    endtask

    task automatic send_range(input tb_frame_t f, input logic [7:0] adj, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_byte(frame_byte(f, adj, k));
    endtask

    task automatic idle();
        DIN_VALID = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        int t0;
        f1 = '{freq: 48'h0123456789AB, dfreq: 48'h000000001000, rate: 32'h00000010,
               tstart: 48'h000012345678, n: 16'h0005, ti: 32'd1000, tp: 32'd5000,
               tb1: 32'd20, tb2: 32'd30};
        f2 = '{freq: 48'hA5A5000000FF, dfreq: 48'hFFFFFFFFFFFF, rate: 32'h12345678,
               tstart: 48'hA50000000001, n: 16'hFFFF, ti: 32'hDEADBEEF, tp: 32'h00000001,
               tb1: 32'h0000A5A5, tb2: 32'h80000000};
        f3 = '{freq: 48'h111111111111, dfreq: 48'h222222222222, rate: 32'h33333333,
               tstart: 48'h444444444444, n: 16'h5555, ti: 32'h66666666, tp: 32'h77777777,
               tb1: 32'h88888888, tb2: 32'h99999999};
        f4 = '{freq: 48'h0000000000FE, dfreq: 48'h800000000000, rate: 32'h0000FFFF,
               tstart: 48'h00000000A5A5, n: 16'h0100, ti: 32'hCAFEF00D, tp: 32'h0BADC0DE,
               tb1: 32'h00000007, tb2: 32'h00010000};

        // Reset state
        RESET_N = 1'b0; DIN = 8'h00; DIN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_wr", WR_DATA, 0);
        check("rst_err_crc", ERR_CRC, 0);
        check("rst_err_to", ERR_TIMEOUT, 0);
        check("rst_frame_cnt", FRAME_CNT, 0);
        check("rst_ready", DIN_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_mem_freq", MEM_DDS_freq, 0);
        check("rst_mem_tb2", MEM_Tblank2, 0);
        RESET_N = 1'b1;
        mon_en  = 1'b1;
        step();

        // 1: valid frame, latency and single-cycle strobe
        sb.push_back('{f: f1, cnt: 16'd1});
        send_range(f1, 8'h00, 0, 20);
        check("t1_busy_mid", BUSY, 1);
        check("t1_no_wr_mid", WR_DATA, 0);
        send_range(f1, 8'h00, 21, 41);
        check("t1_wr_latency", WR_DATA, 1);
        check("t1_ready_commit", DIN_READY, 0);
        idle();
        step();
        check("t1_wr_drop", WR_DATA, 0);
        check("t1_busy_after", BUSY, 0);
        check("t1_wr_count", wr_count, 1);

        // 2: bad checksum
        send_range(f1, 8'h01, 0, 41);
        check("t2_err_crc", ERR_CRC, 1);
        check("t2_no_wr", WR_DATA, 0);
        idle();
        step();
        check("t2_err_crc_drop", ERR_CRC, 0);
        check("t2_mem_kept", MEM_DDS_freq, f1.freq);
        check("t2_mem_kept_tb2", MEM_Tblank2, f1.tb2);
        check("t2_frame_cnt", FRAME_CNT, 1);
        check("t2_crc_count", crc_count, 1);
        check("t2_wr_count", wr_count, 1);

        // 3: leading junk, then a frame carrying sync values as data
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("t3_busy_junk", BUSY, 0);
        sb.push_back('{f: f2, cnt: 16'd2});
        send_range(f2, 8'h00, 0, 41);
        check("t3_wr", WR_DATA, 1);
        idle();
        step();
        check("t3_wr_count", wr_count, 2);

        // 4: inter-byte timeout
        send_range(f3, 8'h00, 0, 10);
        idle();
        k = 0;
        while (ERR_TIMEOUT !== 1'b1 && k < TO + 50) begin
            step();
            k++;
        end
        check("t4_timeout_cycles", k, TO);
        check("t4_busy", BUSY, 0);
        check("t4_no_wr", WR_DATA, 0);
        step();
        check("t4_to_drop", ERR_TIMEOUT, 0);
        check("t4_to_count", to_count, 1);
        sb.push_back('{f: f3, cnt: 16'd3});
        send_range(f3, 8'h00, 0, 41);
        check("t4_wr_after", WR_DATA, 1);
        idle();
        step();
        check("t4_wr_count", wr_count, 3);

        // 5: reset in the middle of a frame
        send_range(f1, 8'h00, 0, 20);
        idle();
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        check("t5_mem_freq", MEM_DDS_freq, 0);
        check("t5_mem_n", MEM_N_impuls, 0);
        check("t5_mem_tp", MEM_Interval_Tp, 0);
        check("t5_frame_cnt", FRAME_CNT, 0);
        check("t5_busy", BUSY, 0);
        send_range(f1, 8'h00, 21, 41);
        idle();
        step();
        check("t5_tail_wr_count", wr_count, 3);
        check("t5_tail_crc_count", crc_count, 1);
        check("t5_tail_busy", BUSY, 0);
        check("t5_tail_frame_cnt", FRAME_CNT, 0);

        // 6: back-to-back frames with DIN_VALID held
        sb.push_back('{f: f3, cnt: 16'd1});
        sb.push_back('{f: f4, cnt: 16'd2});
        send_range(f3, 8'h00, 0, 0);
        t0 = last_acc;
        send_range(f3, 8'h00, 1, 41);
        send_range(f4, 8'h00, 0, 41);
        check("t6_span", last_acc - t0, 84);
        check("t6_wr", WR_DATA, 1);
        idle();
        step();
        check("t6_wr_count", wr_count, 5);
        check("t6_frame_cnt", FRAME_CNT, 2);
        check("t6_mem_freq", MEM_DDS_freq, f4.freq);
        check("t6_mem_tb2", MEM_Tblank2, f4.tb2);

        // 6b: frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        step();
        check("t6_cnt_preset", FRAME_CNT, 16'hFFFF);
        sb.push_back('{f: f1, cnt: 16'h0000});
        send_range(f1, 8'h00, 0, 41);
        idle();
        step();
        check("t6_cnt_wrap", FRAME_CNT, 0);
        check("t6_wrap_wr_count", wr_count, 6);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
